// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: pairs UART bytes into 16-bit little-endian samples,
// buffers them and releases one sample per DAC-rate strobe, with prefill,
// pairing timeout, underrun and overflow handling.
module audio_sample_fifo #(
    parameter int unsigned AW      = 4,
    parameter int unsigned PREFILL = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    rx_byte,
    input  logic          rx_received,
    input  logic          sample_ce,
    input  logic          clear_flags,
    output logic [15:0]   sample_out,
    output logic [AW:0]   level,
    output logic          playing,
    output logic          underrun,
    output logic          overflow
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_e;

    typedef enum logic {
        PB_FILL = 1'b0,
        PB_PLAY = 1'b1
    } pb_state_e;

    // byte pairer state
    phase_e          phase_q, phase_d;
    logic [7:0]      low_byte_q, low_byte_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            push_req_c;
    logic [15:0]     push_data_c;

    // playback state
    pb_state_e       pb_state_q, pb_state_d;
    logic            pop_c;
    logic            underrun_set_c;

    // fifo storage and bookkeeping
    logic [15:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [15:0]     sample_out_q, sample_out_d;
    logic            underrun_q, underrun_d;
    logic            overflow_q, overflow_d;
    logic            push_ok_c;
    logic            overflow_set_c;

    // Pairer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q    <= PH_LOW;
            low_byte_q <= 8'h00;
            timer_q    <= '0;
        end else begin
            phase_q    <= phase_d;
            low_byte_q <= low_byte_d;
            timer_q    <= timer_d;
        end
    end

    // Pairer next state: a late high byte still wins over the timeout.
    always_comb begin
        phase_d    = phase_q;
        low_byte_d = low_byte_q;
        timer_d    = timer_q;
        unique case (phase_q)
            PH_LOW: begin
                if (rx_received) begin
                    low_byte_d = rx_byte;
                    timer_d    = '0;
                    phase_d    = PH_HIGH;
                end
            end
            PH_HIGH: begin
                if (rx_received) begin
                    phase_d = PH_LOW;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    phase_d = PH_LOW;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: phase_d = PH_LOW;
        endcase
    end

    // Pairer outputs: push request in the cycle the high byte arrives.
    always_comb begin
        push_req_c  = 1'b0;
        push_data_c = {rx_byte, low_byte_q};
        if (phase_q == PH_HIGH && rx_received) begin
            push_req_c = 1'b1;
        end
    end

    // Playback state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pb_state_q <= PB_FILL;
        end else begin
            pb_state_q <= pb_state_d;
        end
    end

    // Playback next state: start at prefill, fall back to FILL on underrun.
    always_comb begin
        pb_state_d = pb_state_q;
        unique case (pb_state_q)
            PB_FILL: begin
                if (level_q >= (AW+1)'(PREFILL)) begin
                    pb_state_d = PB_PLAY;
                end
            end
            PB_PLAY: begin
                if (sample_ce && level_q == '0) begin
                    pb_state_d = PB_FILL;
                end
            end
            default: pb_state_d = PB_FILL;
        endcase
    end

    // Playback outputs: pop on strobe when data is present, else flag underrun.
    always_comb begin
        pop_c          = 1'b0;
        underrun_set_c = 1'b0;
        if (pb_state_q == PB_PLAY && sample_ce) begin
            if (level_q != '0) begin
                pop_c = 1'b1;
            end else begin
                underrun_set_c = 1'b1;
            end
        end
    end

    // Write admission: a full fifo still accepts when a pop frees a slot.
    always_comb begin
        push_ok_c      = push_req_c && ((level_q < (AW+1)'(DEPTH)) || pop_c);
        overflow_set_c = push_req_c && !push_ok_c;
    end

    // Fifo next state: pointers, occupancy, output sample and sticky flags.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        sample_out_d = sample_out_q;
        underrun_d   = underrun_set_c | (underrun_q & ~clear_flags);
        overflow_d   = overflow_set_c | (overflow_q & ~clear_flags);
        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            sample_out_d = mem_q[rd_ptr_q];
        end
        unique case ({push_ok_c, pop_c})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Fifo control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            sample_out_q <= 16'h0000;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            sample_out_q <= sample_out_d;
            underrun_q   <= underrun_d;
            overflow_q   <= overflow_d;
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= push_data_c;
        end
    end

    assign sample_out = sample_out_q;
    assign level      = level_q;
    assign playing    = (pb_state_q == PB_PLAY);
    assign underrun   = underrun_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Bench for audio_sample_fifo: random and directed stimulus, reference model
// feeding an expectation queue, monitor comparing after each sample_ce.
module tb_audio_sample_fifo;

    localparam int unsigned AW      = 4;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned PREFILL = 8;
    localparam int unsigned TIMEOUT = 1024;

    logic          clk;
    logic          reset_n;
    logic [7:0]    rx_byte;
    logic          rx_received;
    logic          sample_ce;
    logic          clear_flags;
    logic [15:0]   sample_out;
    logic [AW:0]   level;
    logic          playing;
    logic          underrun;
    logic          overflow;

    audio_sample_fifo #(
        .AW      (AW),
        .PREFILL (PREFILL),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_byte     (rx_byte),
        .rx_received (rx_received),
        .sample_ce   (sample_ce),
        .clear_flags (clear_flags),
        .sample_out  (sample_out),
        .level       (level),
        .playing     (playing),
        .underrun    (underrun),
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] out;
        bit          play;
        bit          und;
        bit          ovf;
        int          lvl;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_q[$];
    logic [15:0] m_out;
    logic [7:0]  m_low;
    bit          m_pend;
    longint      m_cyc;
    longint      m_low_cyc;
    bit          m_play;
    bit          m_und;
    bit          m_ovf;
    bit          m_push;
    bit          m_pop;
    logic [15:0] m_pdata;
    int          m_sz;

    // A high byte pairs if it arrives within TIMEOUT cycles of its low byte.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            exp_q.delete();
            m_out  = 16'h0000;
            m_low  = 8'h00;
            m_pend = 1'b0;
            m_cyc  = 0;
            m_low_cyc = 0;
            m_play = 1'b0;
            m_und  = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_cyc++;
            m_sz   = m_q.size();
            m_push = 1'b0;
            if (rx_received) begin
                if (m_pend && (m_cyc - m_low_cyc) <= longint'(TIMEOUT)) begin
                    m_pdata = {rx_byte, m_low};
                    m_push  = 1'b1;
                    m_pend  = 1'b0;
                end else begin
                    m_pend    = 1'b1;
                    m_low     = rx_byte;
                    m_low_cyc = m_cyc;
                end
            end
            if (clear_flags) begin
                m_und = 1'b0;
                m_ovf = 1'b0;
            end
            m_pop = m_play && sample_ce && (m_sz > 0);
            if (m_pop) m_out = m_q.pop_front();
            if (m_push) begin
                if (m_sz < int'(DEPTH) || m_pop) m_q.push_back(m_pdata);
                else m_ovf = 1'b1;
            end
            if (!m_play) begin
                if (m_sz >= int'(PREFILL)) m_play = 1'b1;
            end else if (sample_ce && m_sz == 0) begin
                m_play = 1'b0;
                m_und  = 1'b1;
            end
            if (sample_ce) begin
                exp_q.push_back('{out: m_out, play: m_play, und: m_und, ovf: m_ovf, lvl: m_q.size()});
            end
        end
    end

    // Monitor: the half cycle after each strobe, compare the DUT to the model.
    exp_t e;
    always @(negedge clk) begin
        if (reset_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ce_sample_out", 32'(sample_out), 32'(e.out));
            check("ce_playing",    32'(playing),    32'(e.play));
            check("ce_underrun",   32'(underrun),   32'(e.und));
            check("ce_overflow",   32'(overflow),   32'(e.ovf));
            check("ce_level",      32'(level),      32'(e.lvl));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_byte(input logic [7:0] b);
        rx_byte     = b;
        rx_received = 1'b1;
        tick();
        rx_received = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] s);
        pulse_byte(s[7:0]);
        idle($urandom_range(0, 3));
        pulse_byte(s[15:8]);
        idle($urandom_range(0, 3));
    endtask

    task automatic ce_pulse();
        sample_ce = 1'b1;
        tick();
        sample_ce = 1'b0;
        idle($urandom_range(1, 3));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sample_out"}, 32'(sample_out), 32'h0);
        check({tag, "_level"},      32'(level),      32'h0);
        check({tag, "_playing"},    32'(playing),    32'h0);
        check({tag, "_underrun"},   32'(underrun),   32'h0);
        check({tag, "_overflow"},   32'(overflow),   32'h0);
    endtask

    task automatic do_reset();
        rx_received = 1'b0;
        sample_ce   = 1'b0;
        clear_flags = 1'b0;
        rx_byte     = 8'h00;
        reset_n     = 1'b0;
        #3;
        check_reset_values("rst");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    logic [15:0] fixed_s [4];

    initial begin
        fixed_s[0] = 16'h1234;
        fixed_s[1] = 16'h5678;
        fixed_s[2] = 16'h9ABC;
        fixed_s[3] = 16'hDEF0;
        reset_n = 1'b0;
        do_reset();

        // Prefill reached, eight samples in order, ninth strobe underruns.
        for (int i = 0; i < 8; i++) send_sample(i < 4 ? fixed_s[i] : 16'($urandom));
        idle(2);
        check("a_playing", 32'(playing), 32'h1);
        for (int i = 0; i < 9; i++) ce_pulse();
        check("a_underrun", 32'(underrun), 32'h1);
        check("a_playing_after", 32'(playing), 32'h0);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("a_clear_underrun", 32'(underrun), 32'h0);

        // One below prefill: strobes do nothing; the eighth sample starts play.
        do_reset();
        for (int i = 0; i < 7; i++) send_sample(16'($urandom));
        for (int i = 0; i < 5; i++) ce_pulse();
        check("b_level7", 32'(level), 32'd7);
        check("b_not_playing", 32'(playing), 32'h0);
        check("b_out_zero", 32'(sample_out), 32'h0);
        pulse_byte(8'h11);
        pulse_byte(8'h22);
        check("b_level8", 32'(level), 32'd8);
        check("b_still_fill", 32'(playing), 32'h0);
        tick();
        check("b_play_start", 32'(playing), 32'h1);
        for (int i = 0; i < 8; i++) ce_pulse();

        // Overflow: twenty samples into sixteen slots, first sixteen survive.
        do_reset();
        for (int i = 0; i < 20; i++) send_sample(16'($urandom));
        idle(2);
        check("c_level_full", 32'(level), 32'd16);
        check("c_overflow", 32'(overflow), 32'h1);
        for (int i = 0; i < 16; i++) ce_pulse();
        check("c_level_empty", 32'(level), 32'h0);

        // Pairing timeout, including both sides of the boundary.
        do_reset();
        pulse_byte(8'hAA); idle(1100 - 1); pulse_byte(8'h34); idle(2); pulse_byte(8'h12); idle(3);
        pulse_byte(8'hAA); idle(1000 - 1); pulse_byte(8'h34); idle(3);
        pulse_byte(8'hAA); idle(int'(TIMEOUT) - 1); pulse_byte(8'h34); idle(3);
        pulse_byte(8'hAA); idle(int'(TIMEOUT)); pulse_byte(8'h34); idle(1); pulse_byte(8'h12); idle(3);
        check("d_level4", 32'(level), 32'd4);
        for (int i = 0; i < 4; i++) send_sample(16'($urandom));
        idle(2);
        for (int i = 0; i < 8; i++) ce_pulse();

        // Reset mid-stream with a pending low byte.
        do_reset();
        for (int i = 0; i < 5; i++) send_sample(16'($urandom));
        pulse_byte(8'hEE);
        idle(2);
        check("e_level5", 32'(level), 32'(m_q.size()));
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("mid");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) send_sample(16'($urandom));
        idle(2);
        for (int i = 0; i < 8; i++) ce_pulse();

        // Random traffic: concurrent push, pop, clear and timeouts.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rx_byte     = 8'($urandom);
            rx_received = ($urandom_range(0, 2) == 0);
            sample_ce   = ($urandom_range(0, 3) == 0);
            clear_flags = ($urandom_range(0, 39) == 0);
            tick();
            check("r_level", 32'(level), 32'(m_q.size()));
        end
        rx_received = 1'b0;
        sample_ce   = 1'b0;
        clear_flags = 1'b0;
        idle(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
